// File: rtl/writeback_stage_pkg.sv
// Shared constants and FSM state type for the writeback stage and its register file.
package writeback_stage_pkg;

  localparam int XLEN        = 32;
  localparam int NREG        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int CNN_TIMEOUT = 1024;
  localparam int CNT_W       = $clog2(CNN_TIMEOUT);

  localparam logic [XLEN-1:0] TIMEOUT_VAL = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_regfile_2r1w.sv
// 32-entry integer register file: two asynchronous read ports with write bypass,
// one synchronous write port, x0 reads as zero.
import writeback_stage_pkg::*;

module writeback_stage_regfile_2r1w (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]       rdata1,
  output logic [XLEN-1:0]       rdata2
);

  logic [XLEN-1:0]       regs_reg [NREG];
  logic [REG_ADDR_W-1:0] raddr    [2];
  logic [XLEN-1:0]       rdata    [2];
  logic                  wr_live;

  assign wr_live = we && (waddr != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_live) begin
      regs_reg[waddr] <= wdata;
    end
  end

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      always_comb begin
        if (raddr[gi] == '0) begin
          rdata[gi] = '0;
        end else if (wr_live && (raddr[gi] == waddr)) begin
          rdata[gi] = wdata;
        end else begin
          rdata[gi] = regs_reg[raddr[gi]];
        end
      end
    end
  endgenerate

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits MEM/WB results and asynchronous CNN accelerator
// results into the register file, stalling upstream while a CNN result is due.
import writeback_stage_pkg::*;

module writeback_stage (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [XLEN-1:0]       mem_wb_val,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic                  mem_wb_valid,
  input  logic                  mem_wb_is_cnn,
  input  logic                  cnn_res_valid,
  input  logic [XLEN-1:0]       cnn_res_data,
  output logic                  cnn_res_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  wb_stall,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_val,
  output logic                  cnn_timeout,
  output logic [31:0]           retired_count
);

  wb_state_t             state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  buf_full_reg, buf_full_next;
  logic [XLEN-1:0]       buf_data_reg, buf_data_next;
  logic                  drop_reg, drop_next;

  logic                  wb_we_reg;
  logic [REG_ADDR_W-1:0] wb_rd_reg;
  logic [XLEN-1:0]       wb_val_reg;
  logic                  cnn_timeout_reg;
  logic [31:0]           retired_reg;

  logic                  accept;
  logic                  direct;
  logic                  commit;
  logic [XLEN-1:0]       commit_data;
  logic                  timeout_hit;
  logic                  stall;

  assign cnn_res_ready = !buf_full_reg;
  assign accept        = cnn_res_valid && !buf_full_reg;
  // A result swallowed by the drop flag belongs to an instruction that already timed out.
  assign direct        = accept && !drop_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    buf_full_next = buf_full_reg;
    buf_data_next = buf_data_reg;
    drop_next     = drop_reg;
    commit        = 1'b0;
    commit_data   = mem_wb_val;
    timeout_hit   = 1'b0;
    stall         = 1'b0;

    if (accept && drop_reg) begin
      drop_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (mem_wb_valid && mem_wb_is_cnn) begin
          if (buf_full_reg) begin
            commit        = 1'b1;
            commit_data   = buf_data_reg;
            buf_full_next = 1'b0;
          end else if (direct) begin
            commit      = 1'b1;
            commit_data = cnn_res_data;
          end else begin
            stall      = 1'b1;
            state_next = WAIT;
            cnt_next   = cnt_reg + 1'b1;
          end
        end else begin
          commit = mem_wb_valid;
          if (direct) begin
            buf_full_next = 1'b1;
            buf_data_next = cnn_res_data;
          end
        end
      end
      WAIT: begin
        if (direct) begin
          commit      = 1'b1;
          commit_data = cnn_res_data;
          state_next  = IDLE;
          cnt_next    = '0;
        end else if (cnt_reg == CNT_W'(CNN_TIMEOUT - 1)) begin
          commit      = 1'b1;
          commit_data = TIMEOUT_VAL;
          timeout_hit = 1'b1;
          drop_next   = 1'b1;
          state_next  = IDLE;
          cnt_next    = '0;
        end else begin
          stall    = 1'b1;
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      buf_full_reg    <= 1'b0;
      buf_data_reg    <= '0;
      drop_reg        <= 1'b0;
      wb_we_reg       <= 1'b0;
      wb_rd_reg       <= '0;
      wb_val_reg      <= '0;
      cnn_timeout_reg <= 1'b0;
      retired_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      buf_full_reg    <= buf_full_next;
      buf_data_reg    <= buf_data_next;
      drop_reg        <= drop_next;
      wb_we_reg       <= commit;
      cnn_timeout_reg <= timeout_hit;
      if (commit) begin
        wb_rd_reg   <= mem_wb_rd;
        wb_val_reg  <= commit_data;
        retired_reg <= retired_reg + 32'd1;
      end
    end
  end

  writeback_stage_regfile_2r1w u_regfile (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (commit),
    .waddr  (mem_wb_rd),
    .wdata  (commit_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  assign wb_stall      = stall;
  assign wb_we         = wb_we_reg;
  assign wb_rd         = wb_rd_reg;
  assign wb_val        = wb_val_reg;
  assign cnn_timeout   = cnn_timeout_reg;
  assign retired_count = retired_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: register commits, bypass, CNN wait/buffer/timeout, reset in WAIT.
import writeback_stage_pkg::*;

module tb_writeback_stage;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [XLEN-1:0]       mem_wb_val;
  logic [REG_ADDR_W-1:0] mem_wb_rd;
  logic                  mem_wb_valid;
  logic                  mem_wb_is_cnn;
  logic                  cnn_res_valid;
  logic [XLEN-1:0]       cnn_res_data;
  logic                  cnn_res_ready;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;
  logic                  wb_stall;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_val;
  logic                  cnn_timeout;
  logic [31:0]           retired_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_wb_val   (mem_wb_val),
    .mem_wb_rd    (mem_wb_rd),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_is_cnn(mem_wb_is_cnn),
    .cnn_res_valid(cnn_res_valid),
    .cnn_res_data (cnn_res_data),
    .cnn_res_ready(cnn_res_ready),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .wb_stall     (wb_stall),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_val       (wb_val),
    .cnn_timeout  (cnn_timeout),
    .retired_count(retired_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_wb_valid  = 1'b0;
    mem_wb_is_cnn = 1'b0;
    cnn_res_valid = 1'b0;
  endtask

  // Counts stalled cycles of a CNN instruction that is already presented; returns at its commit cycle.
  task automatic count_stalls(output int stalls, output int pulses, output bit done);
    stalls = 0;
    pulses = 0;
    done   = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      if (wb_stall) begin
        stalls++;
        if (cnn_timeout) pulses++;
        tick();
      end else begin
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    mem_wb_val    = '0;
    mem_wb_rd     = '0;
    cnn_res_data  = '0;
    rs1_addr      = 5'd5;
    rs2_addr      = 5'd7;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if (retired_count !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d, want 0", retired_count); end
    n_checks++;
    if ({wb_we, wb_rd, wb_val, cnn_timeout} !== '0) begin n_fail++; $display("FAIL reset_wb_outputs: got we=%b rd=%0d val=%h to=%b, want all 0", wb_we, wb_rd, wb_val, cnn_timeout); end
    n_checks++;
    if ({wb_stall, cnn_res_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_stall_ready: got stall=%b ready=%b, want 0/1", wb_stall, cnn_res_ready); end
    n_checks++;
    if (rs1_data !== 32'd0) begin n_fail++; $display("FAIL reset_regfile: got x5=%h, want 0", rs1_data); end
    reset_n = 1'b1;
    tick();
    $display("[%0t] reset released", $time);
  endtask

  task automatic test_alu_write();
    mem_wb_valid = 1'b1; mem_wb_is_cnn = 1'b0; mem_wb_rd = 5'd5; mem_wb_val = 32'h1234; rs1_addr = 5'd5;
    #1;
    n_checks++;
    if (rs1_data !== 32'h1234) begin n_fail++; $display("FAIL alu_bypass: got %h, want 00001234", rs1_data); end
    n_checks++;
    if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL alu_no_stall: got %b, want 0", wb_stall); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rs1_data !== 32'h1234) begin n_fail++; $display("FAIL alu_stored: got %h, want 00001234", rs1_data); end
    n_checks++;
    if ({wb_we, wb_rd, wb_val} !== {1'b1, 5'd5, 32'h1234}) begin n_fail++; $display("FAIL alu_wb_regs: got we=%b rd=%0d val=%h, want 1/5/00001234", wb_we, wb_rd, wb_val); end
    n_checks++;
    if (retired_count !== 32'd1) begin n_fail++; $display("FAIL alu_retired: got %0d, want 1", retired_count); end
    $display("[%0t] ALU commit x5=%h retired=%0d", $time, rs1_data, retired_count);
  endtask

  task automatic test_x0_write();
    mem_wb_valid = 1'b1; mem_wb_is_cnn = 1'b0; mem_wb_rd = 5'd0; mem_wb_val = 32'hDEAD; rs2_addr = 5'd0;
    #1;
    n_checks++;
    if (rs2_data !== 32'd0) begin n_fail++; $display("FAIL x0_no_bypass: got %h, want 0", rs2_data); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rs2_data !== 32'd0) begin n_fail++; $display("FAIL x0_reads_zero: got %h, want 0", rs2_data); end
    n_checks++;
    if (retired_count !== 32'd2) begin n_fail++; $display("FAIL x0_retired: got %0d, want 2", retired_count); end
    n_checks++;
    if (wb_we !== 1'b1) begin n_fail++; $display("FAIL x0_wb_we: got %b, want 1", wb_we); end
    $display("[%0t] x0 write dropped, retired=%0d", $time, retired_count);
  endtask

  task automatic test_cnn_wait();
    int stalls;
    mem_wb_valid = 1'b1; mem_wb_is_cnn = 1'b1; mem_wb_rd = 5'd7; mem_wb_val = 32'h0BAD; rs2_addr = 5'd7;
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (wb_stall) stalls++;
      tick();
    end
    n_checks++;
    if (stalls !== 3) begin n_fail++; $display("FAIL cnn_stall_cycles: got %0d, want 3", stalls); end
    n_checks++;
    if (rs2_data !== 32'd0) begin n_fail++; $display("FAIL cnn_x7_before: got %h, want 0", rs2_data); end
    cnn_res_valid = 1'b1; cnn_res_data = 32'hA5;
    #1;
    n_checks++;
    if ({wb_stall, rs2_data} !== {1'b0, 32'hA5}) begin n_fail++; $display("FAIL cnn_commit_cycle: got stall=%b x7=%h, want 0/000000a5", wb_stall, rs2_data); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({rs2_data, retired_count} !== {32'hA5, 32'd3}) begin n_fail++; $display("FAIL cnn_committed: got x7=%h retired=%0d, want 000000a5/3", rs2_data, retired_count); end
    n_checks++;
    if ({wb_stall, cnn_res_ready} !== 2'b01) begin n_fail++; $display("FAIL cnn_after: got stall=%b ready=%b, want 0/1", wb_stall, cnn_res_ready); end
    $display("[%0t] CNN wait commit x7=%h after %0d stalls", $time, rs2_data, stalls);
  endtask

  task automatic test_stray_buffer();
    cnn_res_valid = 1'b1; cnn_res_data = 32'h11;
    #1;
    n_checks++;
    if (cnn_res_ready !== 1'b1) begin n_fail++; $display("FAIL stray_ready_before: got %b, want 1", cnn_res_ready); end
    tick();
    cnn_res_data = 32'h22;
    #1;
    n_checks++;
    if (cnn_res_ready !== 1'b0) begin n_fail++; $display("FAIL stray_backpressure: got %b, want 0", cnn_res_ready); end
    n_checks++;
    if (retired_count !== 32'd3) begin n_fail++; $display("FAIL stray_no_commit: got %0d, want 3", retired_count); end
    tick();
    // Buffered entry has priority over a simultaneous direct result.
    mem_wb_valid = 1'b1; mem_wb_is_cnn = 1'b1; mem_wb_rd = 5'd9; cnn_res_data = 32'h33; rs1_addr = 5'd9;
    #1;
    n_checks++;
    if ({wb_stall, rs1_data} !== {1'b0, 32'h11}) begin n_fail++; $display("FAIL buf_commit_cycle: got stall=%b x9=%h, want 0/00000011", wb_stall, rs1_data); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({cnn_res_ready, rs1_data, retired_count} !== {1'b1, 32'h11, 32'd4}) begin n_fail++; $display("FAIL buf_committed: got ready=%b x9=%h retired=%0d, want 1/00000011/4", cnn_res_ready, rs1_data, retired_count); end
    $display("[%0t] buffered result commit x9=%h", $time, rs1_data);
  endtask

  task automatic test_timeout();
    int stalls, pulses;
    bit done;
    mem_wb_valid = 1'b1; mem_wb_is_cnn = 1'b1; mem_wb_rd = 5'd10; rs1_addr = 5'd10;
    #1;
    count_stalls(stalls, pulses, done);
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL timeout_bound: stall still %b after 2000 cycles, want commit", wb_stall); end
    n_checks++;
    if (stalls !== CNN_TIMEOUT - 1) begin n_fail++; $display("FAIL timeout_stalls: got %0d, want %0d", stalls, CNN_TIMEOUT - 1); end
    n_checks++;
    if (rs1_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL timeout_bypass: got %h, want ffffffff", rs1_data); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({pulses, cnn_timeout} !== {32'd0, 1'b1}) begin n_fail++; $display("FAIL timeout_pulse: got early=%0d now=%b, want 0/1", pulses, cnn_timeout); end
    n_checks++;
    if ({rs1_data, retired_count} !== {32'hFFFF_FFFF, 32'd5}) begin n_fail++; $display("FAIL timeout_commit: got x10=%h retired=%0d, want ffffffff/5", rs1_data, retired_count); end
    cnn_res_valid = 1'b1; cnn_res_data = 32'h44;
    tick();
    n_checks++;
    if (cnn_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_one_cycle: got %b, want 0", cnn_timeout); end
    n_checks++;
    if (cnn_res_ready !== 1'b1) begin n_fail++; $display("FAIL late_discarded: ready got %b, want 1", cnn_res_ready); end
    cnn_res_data = 32'h55;
    tick();
    cnn_res_valid = 1'b0;
    #1;
    n_checks++;
    if (cnn_res_ready !== 1'b0) begin n_fail++; $display("FAIL next_buffered: ready got %b, want 0", cnn_res_ready); end
    mem_wb_valid = 1'b1; mem_wb_is_cnn = 1'b1; mem_wb_rd = 5'd11; rs2_addr = 5'd11;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({rs2_data, retired_count, cnn_res_ready} !== {32'h55, 32'd6, 1'b1}) begin n_fail++; $display("FAIL after_timeout_buf: got x11=%h retired=%0d ready=%b, want 00000055/6/1", rs2_data, retired_count, cnn_res_ready); end
    $display("[%0t] timeout commit x10=ffffffff, late 44 dropped, x11=%h", $time, rs2_data);
  endtask

  task automatic test_reset_in_wait();
    int stalls, pulses;
    bit done;
    mem_wb_valid = 1'b1; mem_wb_is_cnn = 1'b1; mem_wb_rd = 5'd12; rs1_addr = 5'd12; rs2_addr = 5'd7;
    tick();
    tick();
    tick();
    n_checks++;
    if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL wait_before_reset: stall got %b, want 1", wb_stall); end
    reset_n = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if ({wb_stall, cnn_res_ready, retired_count} !== {1'b0, 1'b1, 32'd0}) begin n_fail++; $display("FAIL reset_wait_state: got stall=%b ready=%b retired=%0d, want 0/1/0", wb_stall, cnn_res_ready, retired_count); end
    tick();
    n_checks++;
    if ({rs1_data, rs2_data} !== 64'd0) begin n_fail++; $display("FAIL reset_wait_regs: got x12=%h x7=%h, want 0/0", rs1_data, rs2_data); end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if ({wb_we, retired_count, rs1_data} !== {1'b0, 32'd0, 32'd0}) begin n_fail++; $display("FAIL reset_no_commit: got we=%b retired=%0d x12=%h, want 0/0/0", wb_we, retired_count, rs1_data); end
    // A fresh CNN instruction must see a cleared counter: full timeout length again.
    mem_wb_valid = 1'b1; mem_wb_is_cnn = 1'b1; mem_wb_rd = 5'd12;
    #1;
    count_stalls(stalls, pulses, done);
    n_checks++;
    if (!done || stalls !== CNN_TIMEOUT - 1) begin n_fail++; $display("FAIL reset_counter_cleared: done=%b stalls=%0d, want 1/%0d", done, stalls, CNN_TIMEOUT - 1); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({cnn_timeout, retired_count} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL reset_then_timeout: got to=%b retired=%0d, want 1/1", cnn_timeout, retired_count); end
    $display("[%0t] reset in WAIT abandoned x12, fresh timeout after %0d stalls", $time, stalls);
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_x0_write();
    test_cnn_wait();
    test_stray_buffer();
    test_timeout();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
